// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if
//   Groups the SPI sequencer's control, status and serial-side signals.
//   master modport: the spi_master_ctrl sequencer.
//   slave  modport: whoever issues requests and supplies MISO (system/bench).
//   start, abort : transfer request / cancel
//   miso         : serial data from the SPI slave
//   busy, done   : transfer status and completion pulse
//   cs_n, sclk   : SPI select and clock
//   load_en, shift_en, serial_in : strobes and data to the shift_reg datapath
interface spi_master_ctrl_if;
  logic start;
  logic abort;
  logic miso;
  logic busy;
  logic done;
  logic cs_n;
  logic sclk;
  logic load_en;
  logic shift_en;
  logic serial_in;

  modport master (
    input  start, abort, miso,
    output busy, done, cs_n, sclk, load_en, shift_en, serial_in
  );

  modport slave (
    output start, abort, miso,
    input  busy, done, cs_n, sclk, load_en, shift_en, serial_in
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   Sequencer for an SPI shift_reg datapath: one DATA_LEN-bit, MSB-first,
//   mode 0 (CPOL=0, CPHA=0) transfer per accepted start.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : spi_master_ctrl_if.master (start/abort/miso in; busy/done/cs_n/
//          sclk/load_en/shift_en/serial_in out, all registered)
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

module spi_master_ctrl #(
  parameter int unsigned DATA_LEN = `DATA_LEN,
  parameter int unsigned CLK_DIV  = 2
) (
  input  logic               clk,
  input  logic               rst,
  spi_master_ctrl_if.master  bus
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
  localparam int unsigned BIT_W = $clog2(DATA_LEN + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LEAD,
    S_HIGH,
    S_LOW,
    S_TRAIL
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             load_q, load_d;
  logic             shift_q, shift_d;
  logic             sin_q, sin_d;
  logic             div_end;

  assign div_end = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    load_d  = 1'b0;
    shift_d = 1'b0;
    sin_d   = sin_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          load_d  = 1'b1;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      S_LOAD: begin
        state_d = S_LEAD;
        div_d   = '0;
      end
      // LEAD and LOW both end with an sclk rising edge that samples MISO.
      S_LEAD, S_LOW: begin
        if (div_end) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          sin_d   = bus.miso;
          state_d = S_HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (div_end) begin
          div_d   = '0;
          sclk_d  = 1'b0;
          shift_d = 1'b1;
          bit_d   = bit_q + 1'b1;
          state_d = ((bit_q + 1'b1) == BIT_LAST) ? S_TRAIL : S_LOW;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_TRAIL: begin
        if (div_end) begin
          div_d   = '0;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides whatever phase transition was computed above.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      div_d   = '0;
      bit_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      cs_n_d  = 1'b1;
      sclk_d  = 1'b0;
      load_d  = 1'b0;
      shift_d = 1'b0;
      sin_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      sin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      load_q  <= load_d;
      shift_q <= shift_d;
      sin_q   <= sin_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.sclk      = sclk_q;
  assign bus.load_en   = load_q;
  assign bus.shift_en  = shift_q;
  assign bus.serial_in = sin_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a CLK_DIV=2 instance and a CLK_DIV=1 instance,
// each with a behavioural shift_reg (d_in=8'hA5) and an SPI slave that
// shifts 8'hCD out MSB-first, changing MISO on sclk falling edges.
module tb_spi_master_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_ctrl_if i2 ();
  spi_master_ctrl_if i1 ();

  spi_master_ctrl #(.DATA_LEN(8), .CLK_DIV(2)) dut2 (.clk(clk), .rst(rst), .bus(i2));
  spi_master_ctrl #(.DATA_LEN(8), .CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(i1));

  int passed = 0;
  int total  = 0;

  // shift_reg models (MOSI = sr[7], d_out = sr)
  logic [7:0] sr2 = 8'h00, sr1 = 8'h00;
  always @(posedge clk or posedge rst)
    if (rst) sr2 <= 8'h00;
    else if (i2.load_en) sr2 <= 8'hA5;
    else if (i2.shift_en) sr2 <= {sr2[6:0], i2.serial_in};
  always @(posedge clk or posedge rst)
    if (rst) sr1 <= 8'h00;
    else if (i1.load_en) sr1 <= 8'hA5;
    else if (i1.shift_en) sr1 <= {sr1[6:0], i1.serial_in};

  // slave models: reload while deselected, shift on sclk falling edge
  logic [7:0] sw2 = 8'hCD, sw1 = 8'hCD;
  always @(negedge i2.sclk or posedge i2.cs_n)
    if (i2.cs_n) sw2 = 8'hCD; else sw2 = {sw2[6:0], 1'b0};
  always @(negedge i1.sclk or posedge i1.cs_n)
    if (i1.cs_n) sw1 = 8'hCD; else sw1 = {sw1[6:0], 1'b0};
  assign i2.miso = sw2[7];
  assign i1.miso = sw1[7];

  // event monitor for the CLK_DIV=2 instance
  int n_load = 0, n_shift = 0, n_rise = 0, n_done = 0, n_busy = 0, n_csbad = 0;
  logic prev_sclk2 = 1'b0;
  logic [7:0] mosi_cap = 8'h00;
  always @(negedge clk) begin
    if (i2.load_en === 1'b1) n_load++;
    if (i2.shift_en === 1'b1) n_shift++;
    if (i2.done === 1'b1) n_done++;
    if (i2.busy === 1'b1) n_busy++;
    if (i2.cs_n !== ~i2.busy) n_csbad++;
    if (i2.sclk === 1'b1 && prev_sclk2 === 1'b0) begin
      n_rise++;
      mosi_cap = {mosi_cap[6:0], sr2[7]};
    end
    prev_sclk2 = i2.sclk;
  end

  task automatic wait_done2(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (i2.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    i2.start = 1'b0; i2.abort = 1'b0;
    i1.start = 1'b0; i1.abort = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({i2.busy, i2.done, i2.cs_n, i2.sclk, i2.load_en, i2.shift_en, i2.serial_in} !== 7'b0010000)
      $display("FAIL reset_div2: got %b want 0010000",
               {i2.busy, i2.done, i2.cs_n, i2.sclk, i2.load_en, i2.shift_en, i2.serial_in});
    else passed++;
    total++;
    if ({i1.busy, i1.done, i1.cs_n, i1.sclk, i1.load_en, i1.shift_en, i1.serial_in} !== 7'b0010000)
      $display("FAIL reset_div1: got %b want 0010000",
               {i1.busy, i1.done, i1.cs_n, i1.sclk, i1.load_en, i1.shift_en, i1.serial_in});
    else passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_transfer;
    int l0, s0, r0, d0, b0, c0;
    bit ok;
    @(negedge clk);
    l0 = n_load; s0 = n_shift; r0 = n_rise; d0 = n_done; b0 = n_busy; c0 = n_csbad;
    i2.start = 1'b1;
    @(negedge clk);
    i2.start = 1'b0;
    total++;
    if ({i2.load_en, i2.busy, i2.cs_n} !== 3'b110)
      $display("FAIL accept_cycle: load/busy/cs_n got %b want 110", {i2.load_en, i2.busy, i2.cs_n});
    else passed++;
    wait_done2(200, ok);
    total++;
    if (!ok) $display("FAIL done_timeout: got no done want done within 200 cycles");
    else passed++;
    total++;
    if (sr2 !== 8'hCD) $display("FAIL d_out: got %h want cd", sr2);
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (n_busy - b0 !== 35) $display("FAIL busy_len: got %0d want 35", n_busy - b0);
    else passed++;
    total++;
    if (mosi_cap !== 8'hA5) $display("FAIL mosi_bits: got %b want 10100101", mosi_cap);
    else passed++;
    total++;
    if (n_load - l0 !== 1) $display("FAIL load_count: got %0d want 1", n_load - l0);
    else passed++;
    total++;
    if (n_shift - s0 !== 8) $display("FAIL shift_count: got %0d want 8", n_shift - s0);
    else passed++;
    total++;
    if (n_rise - r0 !== 8) $display("FAIL sclk_rises: got %0d want 8", n_rise - r0);
    else passed++;
    total++;
    if (n_done - d0 !== 1) $display("FAIL done_count: got %0d want 1", n_done - d0);
    else passed++;
    total++;
    if (n_csbad - c0 !== 0) $display("FAIL cs_n_window: got %0d bad cycles want 0", n_csbad - c0);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int gap;
    bit ok;
    @(negedge clk);
    i2.start = 1'b1;
    wait_done2(200, ok);
    total++;
    if (!ok) $display("FAIL b2b_first_done: got no done want done within 200 cycles");
    else passed++;
    gap = 0;
    @(negedge clk);
    gap = 1;
    total++;
    if (i2.load_en !== 1'b1) $display("FAIL b2b_reload: load_en got %b want 1", i2.load_en);
    else passed++;
    while (i2.done !== 1'b1 && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    i2.start = 1'b0;
    total++;
    if (gap !== 36) $display("FAIL b2b_gap: got %0d want 36", gap);
    else passed++;
    @(negedge clk);
    total++;
    if ({i2.load_en, i2.busy} !== 2'b00)
      $display("FAIL b2b_stop: load_en/busy got %b want 00", {i2.load_en, i2.busy});
    else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_ignored;
    int l0, d0, b0;
    bit ok;
    @(negedge clk);
    l0 = n_load; d0 = n_done; b0 = n_busy;
    i2.start = 1'b1;
    @(negedge clk);
    i2.start = 1'b0;
    repeat (9) @(negedge clk);
    i2.start = 1'b1;
    @(negedge clk);
    i2.start = 1'b0;
    wait_done2(200, ok);
    repeat (5) @(negedge clk);
    total++;
    if (n_load - l0 !== 1) $display("FAIL ignore_loads: got %0d want 1", n_load - l0);
    else passed++;
    total++;
    if (n_done - d0 !== 1) $display("FAIL ignore_dones: got %0d want 1", n_done - d0);
    else passed++;
    total++;
    if (n_busy - b0 !== 35) $display("FAIL ignore_busy: got %0d want 35", n_busy - b0);
    else passed++;
  endtask

  task automatic test_abort;
    int d0, n;
    bit ok;
    @(negedge clk);
    d0 = n_done;
    i2.start = 1'b1;
    @(negedge clk);
    i2.start = 1'b0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (i2.shift_en === 1'b1) n++;
      if (n == 3) break;
    end
    total++;
    if (n !== 3) $display("FAIL abort_reach: shifts got %0d want 3", n);
    else passed++;
    i2.abort = 1'b1;
    @(negedge clk);
    i2.abort = 1'b0;
    total++;
    if ({i2.cs_n, i2.sclk, i2.busy, i2.done, i2.load_en, i2.shift_en} !== 6'b100000)
      $display("FAIL abort_outputs: got %b want 100000",
               {i2.cs_n, i2.sclk, i2.busy, i2.done, i2.load_en, i2.shift_en});
    else passed++;
    repeat (40) @(negedge clk);
    total++;
    if (n_done - d0 !== 0) $display("FAIL abort_no_done: got %0d want 0", n_done - d0);
    else passed++;
    // start and abort together in IDLE: start wins
    i2.start = 1'b1;
    i2.abort = 1'b1;
    @(negedge clk);
    i2.start = 1'b0;
    i2.abort = 1'b0;
    total++;
    if ({i2.load_en, i2.busy, i2.cs_n} !== 3'b110)
      $display("FAIL start_abort_idle: got %b want 110", {i2.load_en, i2.busy, i2.cs_n});
    else passed++;
    wait_done2(200, ok);
    total++;
    if (!ok) $display("FAIL start_abort_done: got no done want done");
    else passed++;
    repeat (2) @(negedge clk);
    test_transfer();
  endtask

  task automatic test_async_reset;
    int d0;
    @(negedge clk);
    d0 = n_done;
    i2.start = 1'b1;
    @(negedge clk);
    i2.start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (i2.sclk === 1'b1) break;
    end
    total++;
    if (i2.sclk !== 1'b1) $display("FAIL rst_reach_high: sclk got %b want 1", i2.sclk);
    else passed++;
    #1 rst = 1'b1;
    #1;
    total++;
    if ({i2.sclk, i2.cs_n, i2.busy, i2.done, i2.load_en, i2.shift_en} !== 6'b010000)
      $display("FAIL async_rst: sclk/cs_n/busy/done/load/shift got %b want 010000",
               {i2.sclk, i2.cs_n, i2.busy, i2.done, i2.load_en, i2.shift_en});
    else passed++;
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (n_done - d0 !== 0) $display("FAIL rst_no_done: got %0d want 0", n_done - d0);
    else passed++;
  endtask

  task automatic test_div1;
    int bc;
    bit ok;
    @(negedge clk);
    i1.start = 1'b1;
    @(negedge clk);
    i1.start = 1'b0;
    bc = (i1.busy === 1'b1) ? 1 : 0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (i1.busy === 1'b1) bc++;
      if (i1.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) $display("FAIL div1_done: got no done want done within 100 cycles");
    else passed++;
    total++;
    if (bc !== 18) $display("FAIL div1_busy: got %0d want 18", bc);
    else passed++;
    total++;
    if (sr1 !== 8'hCD) $display("FAIL div1_d_out: got %h want cd", sr1);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_transfer();
    test_back_to_back();
    test_start_ignored();
    test_abort();
    test_async_reset();
    test_div1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
